dwa_element_selector: RTL and testbench

//  Downstream stage of the second-order IIR notch filter. Quantises the filter's
//  2*WIDTH-bit signed output to one of N_ELEM+1 levels and drives the unit-element
//  DAC array through data-weighted averaging (DWA): a rotating pointer spreads

---
 rtl/dwa_element_selector.sv | 123 ++++++++++++
 tb/tb_dwa_element_selector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwa_element_selector.sv
`timescale 1ns/1ps
// Purpose : quantise a signed filter sample to 0..N_ELEM levels and select unit DAC
//           elements by data-weighted averaging (rotating pointer).
// Latency : 2 cycles, sample at edge k -> elem_sel/out_valid at edge k+2. No backpressure;
//           one sample per cycle. A bubble gives out_valid=0 with the outputs held.
// Ports   : clk, reset (synchronous, active-low), in_valid, sample_in (signed), dem_en
//           (1 = rotate, 0 = fixed thermometer from element 0) -> out_valid, elem_sel,
//           level_out (popcount of elem_sel), ptr_out (pointer used), sat_flag (sticky clamp).
module dwa_element_selector #(
   parameter int IN_WIDTH = 32,
   parameter int N_ELEM   = 16,
   parameter int SHIFT    = 27
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic signed [IN_WIDTH-1:0]    sample_in,
   input  logic                          dem_en,
   output logic                          out_valid,
   output logic [N_ELEM-1:0]             elem_sel,
   output logic [$clog2(N_ELEM+1)-1:0]   level_out,
   output logic [$clog2(N_ELEM)-1:0]     ptr_out,
   output logic                          sat_flag
);

   localparam int LW = $clog2(N_ELEM+1);
   localparam int PW = $clog2(N_ELEM);
   localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(N_ELEM/2);
   localparam logic signed [IN_WIDTH:0] FULL = (IN_WIDTH+1)'(N_ELEM);

   // ---------------- stage 1: quantise and clamp ----------------
   logic signed [IN_WIDTH:0] w_ext;
   logic signed [IN_WIDTH:0] w_q;
   logic                     w_under;
   logic                     w_over;
   logic [LW-1:0]            w_level;

   always_comb begin
      // One extra bit of headroom so the level offset can never overflow.
      w_ext   = {sample_in[IN_WIDTH-1], sample_in};
      w_q     = (w_ext >>> SHIFT) + HALF;
      w_under = w_q[IN_WIDTH];
      w_over  = !w_q[IN_WIDTH] && (w_q > FULL);
      if (w_under) begin
         w_level = '0;
      end else if (w_over) begin
         w_level = LW'(N_ELEM);
      end else begin
         w_level = w_q[LW-1:0];
      end
   end

   logic          r_s1_vld;
   logic [LW-1:0] r_s1_level;
   logic          r_s1_clamp;

   // ---------------- stage 2: element selection ----------------
   logic [PW-1:0]       r_ptr;
   logic [N_ELEM:0]     w_therm_x;
   logic [N_ELEM-1:0]   w_therm;
   logic [2*N_ELEM-1:0] w_rot;
   logic [N_ELEM-1:0]   w_mask;
   logic [LW-1:0]       w_ptr_sum;

   always_comb begin
      // level ones from bit 0; one spare bit so level == N_ELEM gives all ones
      w_therm_x = ((N_ELEM+1)'(1) << r_s1_level) - (N_ELEM+1)'(1);
      w_therm   = w_therm_x[N_ELEM-1:0];
      // Rotate left by the pointer: the upper half of the doubled mask wraps the
      // bits that run past element N_ELEM-1 back to element 0.
      w_rot     = {w_therm, w_therm} << r_ptr;
      w_mask    = dem_en ? w_rot[2*N_ELEM-1:N_ELEM] : w_therm;
      // N_ELEM is a power of two, so dropping the carry is the modulo.
      w_ptr_sum = LW'(r_ptr) + r_s1_level;
   end

   logic              r_out_vld;
   logic [N_ELEM-1:0] r_elem;
   logic [LW-1:0]     r_level;
   logic [PW-1:0]     r_ptr_out;
   logic              r_sat;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1_vld   <= 1'b0;
         r_s1_level <= '0;
         r_s1_clamp <= 1'b0;
         r_ptr      <= '0;
         r_out_vld  <= 1'b0;
         r_elem     <= '0;
         r_level    <= '0;
         r_ptr_out  <= '0;
         r_sat      <= 1'b0;
      end else begin
         r_s1_vld <= in_valid;
         if (in_valid) begin
            r_s1_level <= w_level;
            r_s1_clamp <= w_under | w_over;
         end
         r_out_vld <= r_s1_vld;
         // Bubbles leave the output registers and the pointer untouched.
         if (r_s1_vld) begin
            r_elem    <= w_mask;
            r_level   <= r_s1_level;
            r_ptr_out <= r_ptr;
            // Flag rises with the output of the clamped sample itself.
            if (r_s1_clamp) begin
               r_sat <= 1'b1;
            end
            if (dem_en) begin
               r_ptr <= w_ptr_sum[PW-1:0];
            end
         end
      end
   end

   assign out_valid = r_out_vld;
   assign elem_sel  = r_elem;
   assign level_out = r_level;
   assign ptr_out   = r_ptr_out;
   assign sat_flag  = r_sat;

endmodule

// File: tb/tb_dwa_element_selector.sv
`timescale 1ns/1ps
module tb_dwa_element_selector;
   localparam int IW = 32;
   localparam int NE = 16;
   localparam int SH = 27;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          dem_en = 1'b1;
   logic [IW-1:0] sample_in = '0;
   logic          out_valid;
   logic [NE-1:0] elem_sel;
   logic [4:0]    level_out;
   logic [3:0]    ptr_out;
   logic          sat_flag;

   dwa_element_selector #(.IN_WIDTH(IW), .N_ELEM(NE), .SHIFT(SH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .sample_in (sample_in),
      .dem_en    (dem_en),
      .out_valid (out_valid),
      .elem_sel  (elem_sel),
      .level_out (level_out),
      .ptr_out   (ptr_out),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic rst_q = 1'b0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   typedef struct {
      logic [NE-1:0] elem;
      logic [4:0]    lvl;
      logic [3:0]    ptr;
      logic          sat;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mx;
   int   n_vec = 0;
   int   n_miss = 0;

   logic [NE-1:0] last_elem = '0;
   logic [4:0]    last_lvl  = '0;
   logic [3:0]    last_ptr  = '0;
   logic          last_sat  = 1'b0;

   bit acc_en = 1'b0;
   int use_cnt [NE];
   int mn_c;
   int mx_c;

   int m_ptr = 0;
   bit m_sat = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issue one valid sample with its hand-computed response.
   task automatic send(input logic [31:0] s, input logic [NE-1:0] e, input int l,
                       input int p, input bit st);
      exp_t x;
      x.elem = e;
      x.lvl  = 5'(l);
      x.ptr  = 4'(p);
      x.sat  = st;
      x.cyc  = cyc + 2;
      sb.push_back(x);
      in_valid  = 1'b1;
      sample_in = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model for the random section (dem_en held at 1).
   task automatic send_model(input logic [31:0] s);
      int            q;
      logic [NE-1:0] m;
      q = ($signed(s) >>> SH) + NE/2;
      if (q < 0) begin
         q = 0;
         m_sat = 1'b1;
      end else if (q > NE) begin
         q = NE;
         m_sat = 1'b1;
      end
      m = '0;
      for (int i = 0; i < q; i++) m[(m_ptr + i) % NE] = 1'b1;
      send(s, m, q, m_ptr, m_sat);
      m_ptr = (m_ptr + q) % NE;
   endtask

   // Monitor: pops the scoreboard on every valid output, checks hold on bubbles.
   always @(negedge clk) begin
      if (!rst_q) begin
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_elem_sel", 32'(elem_sel), 32'd0);
         last_elem = '0;
         last_lvl  = '0;
         last_ptr  = '0;
         last_sat  = 1'b0;
      end else if (out_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_output: got out_valid=1 elem_sel=0x%0h, expected none pending", elem_sel);
         end else begin
            mx = sb.pop_front();
            chk("elem_sel",  32'(elem_sel),  32'(mx.elem));
            chk("level_out", 32'(level_out), 32'(mx.lvl));
            chk("ptr_out",   32'(ptr_out),   32'(mx.ptr));
            chk("sat_flag",  32'(sat_flag),  32'(mx.sat));
            chk("latency",   32'(cyc),       32'(mx.cyc));
            chk("popcount",  32'($countones(elem_sel)), 32'(level_out));
            last_elem = mx.elem;
            last_lvl  = mx.lvl;
            last_ptr  = mx.ptr;
            last_sat  = mx.sat;
            if (acc_en) begin
               for (int i = 0; i < NE; i++) if (elem_sel[i]) use_cnt[i]++;
               mn_c = use_cnt[0];
               mx_c = use_cnt[0];
               for (int i = 1; i < NE; i++) begin
                  if (use_cnt[i] < mn_c) mn_c = use_cnt[i];
                  if (use_cnt[i] > mx_c) mx_c = use_cnt[i];
               end
               chk("use_balance", 32'(mx_c - mn_c <= 1), 32'd1);
            end
         end
      end else begin
         chk("hold_elem",  32'(elem_sel),  32'(last_elem));
         chk("hold_level", 32'(level_out), 32'(last_lvl));
         chk("hold_ptr",   32'(ptr_out),   32'(last_ptr));
         chk("hold_sat",   32'(sat_flag),  32'(last_sat));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < NE; i++) use_cnt[i] = 0;

      // 1: reset held 3 cycles with valid, saturating input applied
      reset     = 1'b0;
      in_valid  = 1'b1;
      sample_in = 32'h7FFF_FFFF;
      dem_en    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_elem_sel",  32'(elem_sel),  32'd0);
      chk("reset_level_out", 32'(level_out), 32'd0);
      chk("reset_ptr_out",   32'(ptr_out),   32'd0);
      chk("reset_sat_flag",  32'(sat_flag),  32'd0);
      reset = 1'b1;

      // 2: mid-scale, back to back (first one also checks post-reset latency)
      send(32'h0000_0000, 16'h00FF, 8, 0, 1'b0);
      send(32'h0000_0000, 16'hFF00, 8, 8, 1'b0);
      send(32'h0000_0000, 16'h00FF, 8, 0, 1'b0);
      send(32'h0000_0000, 16'hFF00, 8, 8, 1'b0);

      // 3: wrap, levels 14 then 4 -> pointer ends at 2
      send(32'h3000_0000, 16'h3FFF, 14, 0, 1'b0);
      send(32'hE000_0000, 16'hC003, 4, 14, 1'b0);

      // exact full scale and exact zero: no clamp, pointer unchanged
      send(32'h4000_0000, 16'hFFFF, 16, 2, 1'b0);
      send(32'hC000_0000, 16'h0000, 0, 2, 1'b0);

      // 4: saturation both ways; flag sticks
      send(32'h7FFF_FFFF, 16'hFFFF, 16, 2, 1'b1);
      send(32'h8000_0000, 16'h0000, 0, 2, 1'b1);
      // -1 floors to -1 -> level 7 from pointer 2, pointer -> 9
      send(32'hFFFF_FFFF, 16'h01FC, 7, 2, 1'b1);
      idle(3);

      // 5: fixed thermometer, level 5, pointer held at 9
      dem_en = 1'b0;
      send(32'hE800_0000, 16'h001F, 5, 9, 1'b1);
      send(32'hE800_0000, 16'h001F, 5, 9, 1'b1);
      send(32'hE800_0000, 16'h001F, 5, 9, 1'b1);
      idle(3);
      dem_en = 1'b1;
      send(32'hE800_0000, 16'h3E00, 5, 9, 1'b1);
      send(32'hE800_0000, 16'hC007, 5, 14, 1'b1);
      idle(3);

      // 6: random bubbles and samples against the model
      m_ptr  = 3;
      m_sat  = 1'b1;
      acc_en = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 9) < 7) begin
            int            qq;
            logic [31:0]   s;
            qq = int'($urandom_range(0, 24)) - 12;
            s  = (32'(qq) << SH) | 32'($urandom_range(0, 32'h07FF_FFFF));
            send_model(s);
         end else begin
            idle(1);
         end
      end
      idle(3);
      acc_en = 1'b0;

      // mid-stream reset: second sample is in stage 1 and must be flushed
      send_model(32'h0000_0000);
      send_model(32'h0000_0000);
      reset = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      m_ptr = 0;
      m_sat = 1'b0;
      idle(2);
      send_model(32'h0000_0000);
      send_model(32'h3000_0000);

      begin
         int t;
         t = 0;
         while (sb.size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
         end
      end
      @(negedge clk);
      chk("drain_pending", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
